eda_img_win_ram: RTL
====================

EDA_IMG_WIN_RAM -- requirements
Module: eda_img_win_ram

Interface
REQ-001 Parameter M, default 8: image rows.
REQ-002 Parameter N, default 8: image columns.
REQ-003 Parameter PIXEL_WIDTH, default 8: bits per pixel.
REQ-004 Parameter R, default 1, range 1..3: window radius; K = 2R+1, window holds K*K pixels.
REQ-005 Parameter I_WIDTH, default 3: row index width, with 2^I_WIDTH >= M.
REQ-006 Parameter J_WIDTH, default 3: column index width, with 2^J_WIDTH >= N.
REQ-007 Derived ADDR_WIDTH = I_WIDTH+J_WIDTH; address = {i, j}.
REQ-008 clk  in  1  clock; reset reset_n, asynchronous, active-low.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 frame_clr  in  1  synchronous pulse: abort the current frame, return to LOAD.
REQ-011 wr_valid  in  1  pixel-stream valid.
REQ-012 wr_ready  out  1  pixel stream accepted; high only in LOAD.
REQ-013 wr_pixel  in  PIXEL_WIDTH  pixel, raster order (row-major from {0,0}).
REQ-014 frame_loaded  out  1  high while the full M*N frame is resident.
REQ-015 border_mode  in  1  0 = zero-fill, 1 = replicate nearest edge pixel; sampled at request accept.
REQ-016 rd_valid  in  1  window request valid.
REQ-017 rd_ready  out  1  request accepted when rd_valid && rd_ready.
REQ-018 rd_addr  in  ADDR_WIDTH  window centre {i, j}.
REQ-019 win_valid  out  1  window output valid.
REQ-020 win_ready  in  1  downstream accepts window.
REQ-021 win_values  out  K*K*PIXEL_WIDTH  window pixels; index k = (di+R)*K + (dj+R); slot k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH], row -R first.
REQ-022 win_mask  out  K*K  bit k set iff neighbour k lies inside the image; the centre bit is always 1.
REQ-023 win_addr  out  ADDR_WIDTH  centre address of the presented window.
REQ-024 rd_err  out  1  one-cycle pulse: the accepted request had i >= M or j >= N.

Function
REQ-025 States: LOAD, READY, BUSY; reset state is LOAD.
REQ-026 LOAD, pixel write:
- On wr_valid && wr_ready, write wr_pixel to the internal counter address {wr_i, wr_j}.
- Then increment wr_j; on wr_j = N-1, wrap wr_j to 0 and increment wr_i.
REQ-027 LOAD, frame end:
- On the write of {M-1, N-1}, clear the counters and move to READY.
- frame_loaded rises in the next cycle.
REQ-028 rd_ready = 1 in READY, and in BUSY when the output register is empty or is being drained in the same cycle (win_ready high); otherwise 0.
REQ-029 Request accept:
- Register the window, mask, address and border_mode result.
- win_valid is asserted in the cycle after accept (latency 1).
- State is BUSY while win_valid is high.
REQ-030 While win_valid && !win_ready, win_values, win_mask and win_addr are held stable and no request is accepted.
REQ-031 On win_valid && win_ready && !rd_valid: clear win_valid and return to READY.
- Back-to-back accept gives one window per cycle with no bubble.
REQ-032 Offsets di, dj span -R..R.
- The neighbour is inside iff 0 <= i+di <= M-1 and 0 <= j+dj <= N-1.
- Comparisons use signed arithmetic of width I_WIDTH+2 and J_WIDTH+2; no modular wrap.
REQ-033 Neighbour outside the image:
- border_mode=0: slot = 0.
- border_mode=1: slot = pixel at the coordinates clamped to [0, M-1] x [0, N-1].
- The mask bit is 0 in both modes.
REQ-034 Out-of-range centre request:
- The request is accepted and rd_err pulses.
- win_values, win_mask = 0; win_valid is still asserted.
REQ-035 frame_clr:
- Clears win_valid and the counters and forces LOAD.
- Pixel memory contents are undefined afterwards.
- frame_clr takes priority over every simultaneous event.
REQ-036 In READY and BUSY, wr_ready = 0 and wr_valid is ignored; the memory is not modified.
REQ-037 Memory is M*N*PIXEL_WIDTH registers, not reset; the read path is combinational into the output register.

Reset
REQ-038 On reset_n low:
- State = LOAD; counters = 0.
- wr_ready = 1 (combinational from state); frame_loaded = 0; rd_ready = 0.
- win_valid = 0; win_values = 0; win_mask = 0; win_addr = 0; rd_err = 0.
REQ-039 Reset asserted mid-frame or mid-handshake discards all progress; after release the block accepts pixels from {0,0}.

Verification (M=N=8, R=1, PIXEL_WIDTH=8, pixel{i,j} = 8*i+j)
REQ-040 Load scenario: stream 64 pixels -> frame_loaded = 1 after the last write; wr_ready = 0; rd_ready = 1.
REQ-041 Corner scenario: request {0,0}, border_mode=0 ->
- win_valid in the next cycle.
- win_mask = 9'b110110000.
- win_values slots 4,5,7,8 = 0, 1, 8, 9; all other slots = 0.
REQ-042 Replicate scenario: request {7,7}, border_mode=1 ->
- Slots 0..8 = 54, 55, 55, 62, 63, 63, 62, 63, 63.
- win_mask = 9'b000011011.
REQ-043 Stall scenario:
- Requests {3,3} then {4,4}, win_ready low for 3 cycles.
- Expected: the {3,3} window is held stable and rd_ready = 0.
- Then win_ready high: {4,4} is presented in the cycle after drain; no window is lost or duplicated.
REQ-044 Error scenario: request {9,2} on M=8 (I_WIDTH=4) -> rd_err pulse; win_mask = 0; win_valid = 1.
REQ-045 Abort scenario: frame_clr in BUSY with win_valid high -> next cycle win_valid = 0, state LOAD, wr_ready = 1; a reload of 64 pixels succeeds.

Source files
------------

// File: rtl/eda_img_win_ram.sv
// ============================================================================
// eda_img_win_ram : frame-buffered KxK window extractor with border handling
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module eda_img_win_ram #(
    parameter int M           = 8,
    parameter int N           = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int R           = 1,
    parameter int I_WIDTH     = 3,
    parameter int J_WIDTH     = 3,
    localparam int K          = 2 * R + 1,
    localparam int ADDR_WIDTH = I_WIDTH + J_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_clr,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [PIXEL_WIDTH-1:0]       wr_pixel,
    output logic                         frame_loaded,
    input  logic                         border_mode,
    input  logic                         rd_valid,
    output logic                         rd_ready,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [K*K*PIXEL_WIDTH-1:0]   win_values,
    output logic [K*K-1:0]               win_mask,
    output logic [ADDR_WIDTH-1:0]        win_addr,
    output logic                         rd_err
);

    localparam int MN    = M * N;
    localparam int IDX_W = (MN > 1) ? $clog2(MN) : 1;
    localparam logic signed [I_WIDTH+1:0] I_MAX = (I_WIDTH+2)'(M - 1);
    localparam logic signed [J_WIDTH+1:0] J_MAX = (J_WIDTH+2)'(N - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t                        state_q;
    logic [I_WIDTH-1:0]            wr_i_q;
    logic [J_WIDTH-1:0]            wr_j_q;
    logic [PIXEL_WIDTH-1:0]        mem_q [MN];
    logic                          win_valid_q;
    logic                          rd_err_q;
    logic [K*K*PIXEL_WIDTH-1:0]    win_values_q;
    logic [K*K-1:0]                win_mask_q;
    logic [ADDR_WIDTH-1:0]         win_addr_q;

    logic [K*K*PIXEL_WIDTH-1:0]    win_values_d;
    logic [K*K-1:0]                win_mask_d;
    logic                          oob_d;
    logic                          wr_fire;
    logic                          rd_fire;
    logic                          wr_last;
    logic [IDX_W-1:0]              wr_idx;
    logic [I_WIDTH-1:0]            ci;
    logic [J_WIDTH-1:0]            cj;

    assign wr_ready     = (state_q == ST_LOAD);
    assign frame_loaded = (state_q != ST_LOAD);
    assign rd_ready     = (state_q == ST_READY) ||
                          ((state_q == ST_BUSY) && (!win_valid_q || win_ready));
    assign wr_fire      = reset_n && wr_valid && wr_ready && !frame_clr;
    assign rd_fire      = rd_valid && rd_ready && !frame_clr;
    assign wr_last      = (wr_i_q == I_WIDTH'(M - 1)) && (wr_j_q == J_WIDTH'(N - 1));
    assign wr_idx       = IDX_W'(int'(wr_i_q) * N + int'(wr_j_q));

    assign ci    = rd_addr[ADDR_WIDTH-1:J_WIDTH];
    assign cj    = rd_addr[J_WIDTH-1:0];
    assign oob_d = ($signed({2'b00, ci}) > I_MAX) || ($signed({2'b00, cj}) > J_MAX);

    // Each neighbour resolves its own clamped coordinate; outside pixels use it only in replicate mode.
    for (genvar a = 0; a < K; a++) begin : g_row
        for (genvar b = 0; b < K; b++) begin : g_col
            localparam int KI = a * K + b;
            localparam logic signed [I_WIDTH+1:0] DI = (I_WIDTH+2)'(a - R);
            localparam logic signed [J_WIDTH+1:0] DJ = (J_WIDTH+2)'(b - R);

            logic signed [I_WIDTH+1:0] ii;
            logic signed [J_WIDTH+1:0] jj;
            logic                      in_row;
            logic                      in_col;
            logic [I_WIDTH-1:0]        ic;
            logic [J_WIDTH-1:0]        jc;
            logic [IDX_W-1:0]          idx;
            logic [PIXEL_WIDTH-1:0]    pix;

            assign ii     = $signed({2'b00, ci}) + DI;
            assign jj     = $signed({2'b00, cj}) + DJ;
            assign in_row = !ii[I_WIDTH+1] && (ii <= I_MAX);
            assign in_col = !jj[J_WIDTH+1] && (jj <= J_MAX);
            assign ic     = ii[I_WIDTH+1] ? '0 : (in_row ? ii[I_WIDTH-1:0] : I_MAX[I_WIDTH-1:0]);
            assign jc     = jj[J_WIDTH+1] ? '0 : (in_col ? jj[J_WIDTH-1:0] : J_MAX[J_WIDTH-1:0]);
            assign idx    = IDX_W'(int'(ic) * N + int'(jc));
            assign pix    = mem_q[idx];

            assign win_mask_d[KI] = !oob_d && in_row && in_col;
            assign win_values_d[KI*PIXEL_WIDTH +: PIXEL_WIDTH] =
                (oob_d || !((in_row && in_col) || border_mode)) ? '0 : pix;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_idx] <= wr_pixel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_LOAD;
            wr_i_q       <= '0;
            wr_j_q       <= '0;
            win_valid_q  <= 1'b0;
            rd_err_q     <= 1'b0;
            win_values_q <= '0;
            win_mask_q   <= '0;
            win_addr_q   <= '0;
        end else if (frame_clr) begin
            state_q     <= ST_LOAD;
            wr_i_q      <= '0;
            wr_j_q      <= '0;
            win_valid_q <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            rd_err_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (wr_valid) begin
                        if (wr_last) begin
                            wr_i_q  <= '0;
                            wr_j_q  <= '0;
                            state_q <= ST_READY;
                        end else if (wr_j_q == J_WIDTH'(N - 1)) begin
                            wr_j_q <= '0;
                            wr_i_q <= wr_i_q + I_WIDTH'(1);
                        end else begin
                            wr_j_q <= wr_j_q + J_WIDTH'(1);
                        end
                    end
                end
                ST_READY, ST_BUSY: begin
                    if (rd_fire) begin
                        state_q      <= ST_BUSY;
                        win_valid_q  <= 1'b1;
                        win_values_q <= win_values_d;
                        win_mask_q   <= win_mask_d;
                        win_addr_q   <= rd_addr;
                        rd_err_q     <= oob_d;
                    end else if (win_valid_q && win_ready) begin
                        win_valid_q <= 1'b0;
                        state_q     <= ST_READY;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign win_valid  = win_valid_q;
    assign win_values = win_values_q;
    assign win_mask   = win_mask_q;
    assign win_addr   = win_addr_q;
    assign rd_err     = rd_err_q;

endmodule

`default_nettype wire
